frame_avg: RTL and testbench
============================

FRAME_AVG -- requirements
Module: frame_avg

Interface
REQ-001 SHALL have parameter IMAGE_DIM, default 512, meaning image width/height in pixels (square frame).
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, meaning bits per unsigned pixel.
REQ-003 SHALL have parameter LANES, default 16, meaning pixels packed per word; DATA_WIDTH = PIXEL_WIDTH*LANES (default 128).
REQ-004 SHALL have parameter ADDR_WIDTH, default 14, meaning storage address bits; WORDS = IMAGE_DIM*IMAGE_DIM/LANES, which SHALL be <= 2^ADDR_WIDTH.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port stall, input, 1, meaning a global pipeline freeze.
REQ-008 SHALL have port clear, input, 1, meaning a synchronous restart of frame history.
REQ-009 SHALL have port mode, input, 2, meaning 0 pass-through, 1 pairwise mean, 2 exponential average, 3 reserved (treated as 0).
REQ-010 SHALL have port k_shift, input, 3, meaning the exponential weight exponent K (weight 2^-K).
REQ-011 SHALL have port ivalid, input, 1, meaning idata is valid this cycle.
REQ-012 SHALL have port idata, input, DATA_WIDTH, meaning packed input pixels, lane 0 in LSBs.
REQ-013 SHALL have port ovalid, output, 1, meaning odata is valid this cycle.
REQ-014 SHALL have port odata, output, DATA_WIDTH, meaning packed averaged pixels.
REQ-015 SHALL have port frame_done, output, 1, meaning a one-cycle pulse with the last output word of each frame.

Function
REQ-016 SHALL accept a word when ivalid=1 and stall=0; no backpressure exists beyond stall.
REQ-017 SHALL freeze all registers, pointers and storage enables while stall=1, with ovalid/odata held.
REQ-018 SHALL use two states: UNSET (no stored frame) and SET (stored frame valid).
REQ-019 SHALL in UNSET output each input word unchanged and write it to storage at write_ptr.
REQ-020 SHALL in SET read the stored word at the current pointer and compute the output per lane: mode 1 gives (x+p+1)>>1; mode 2 gives p + ((x-p)>>>K) in PIXEL_WIDTH+1 signed arithmetic; mode 0 gives x.
REQ-021 SHALL in SET write back x in modes 0/1 and the computed result in mode 2.
REQ-022 SHALL pipeline in two stages (accept/read, then compute/write/register), giving ovalid exactly 2 unstalled cycles after acceptance.
REQ-023 SHALL never overflow or underflow a lane result; results SHALL fit PIXEL_WIDTH, and K=0 in mode 2 SHALL give x.
REQ-024 SHALL wrap the pointer from WORDS-1 to 0, move UNSET->SET on the first wrap, and assert frame_done with the corresponding output word.
REQ-025 SHALL latch mode and k_shift only when accepting the word at pointer 0; changes mid-frame take effect next frame.
REQ-026 SHALL, when clear=1 and stall=0, return to UNSET with pointer 0 and flush in-flight words (no ovalid); clear SHALL take priority over ivalid.
REQ-027 SHALL in storage give a read address that never equals the same-cycle write address for WORDS >= 2 (no read-during-write hazard).

Reset
REQ-028 SHALL on aresetn=0 immediately set state UNSET, pointers 0, ovalid 0, odata 0, frame_done 0 and latched mode 0, regardless of clock or stall.
REQ-029 SHALL not clear storage contents on reset; UNSET guarantees they are unused.

Structure
REQ-030 SHALL place mode encodings and state encodings in a shared package frame_avg_pkg.
REQ-031 SHALL instantiate one sub-module, lsu (simple dual-port RAM, WORDS x DATA_WIDTH, 1-cycle synchronous read).
REQ-032 SHALL implement the per-lane arithmetic with a generate loop over LANES.

Verification (IMAGE_DIM=4, LANES=4, PIXEL_WIDTH=8, ADDR_WIDTH=2, WORDS=4)
REQ-033 SHALL cover this scenario: frame of lanes all 0x10, then mode 1 with a frame of all 0x21 -> first frame echoes 0x10, second outputs 0x19 per lane, frame_done on words 3 and 7.
REQ-034 SHALL cover this scenario: mode 2, K=2, stored 0x00, input 0xFF -> 0x3F; next frame with 0xFF -> 0x6F.
REQ-035 SHALL cover this scenario: mode 2, stored 0xFF, input 0x00, K=1 -> 0x7F (negative delta, no underflow).
REQ-036 SHALL cover this scenario: stall held 5 cycles mid-frame -> outputs identical to the unstalled run, latency 2 active cycles preserved.
REQ-037 SHALL cover this scenario: clear at word 2 of the second frame -> no ovalid for in-flight words, next frame echoed unchanged (UNSET).
REQ-038 SHALL cover this scenario: aresetn pulsed low mid-frame between clock edges -> ovalid/odata 0 immediately, next frame echoed unchanged.

Source files
------------

// File: rtl/frame_avg_pkg.sv
// Shared encodings for the frame averaging block: operating modes and the
// frame-history state.
package frame_avg_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MEAN = 2'd1,
    MODE_EMA  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    ST_UNSET = 1'b0,
    ST_SET   = 1'b1
  } state_e;

endpackage

// File: rtl/frame_avg_if.sv
// Pixel stream bundle: input word with valid, averaged output word with
// valid and end-of-frame marker.
interface frame_avg_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  ivalid;
  logic [DATA_WIDTH-1:0] idata;
  logic                  ovalid;
  logic [DATA_WIDTH-1:0] odata;
  logic                  frame_done;

  modport master (
    output ivalid, idata,
    input  ovalid, odata, frame_done
  );

  modport slave (
    input  ivalid, idata,
    output ovalid, odata, frame_done
  );
endinterface

// File: rtl/frame_avg_lsu.sv
// Frame history store: simple dual-port RAM with a registered read port.
// Contents are deliberately not reset.
module frame_avg_lsu #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned WORDS      = 16384
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_avg.sv
// Temporal frame averager: pass-through, pairwise mean or exponential
// average of each pixel against the stored previous frame.
module frame_avg
  import frame_avg_pkg::*;
#(
  parameter int unsigned IMAGE_DIM   = 512,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned LANES       = 16,
  parameter int unsigned ADDR_WIDTH  = 14
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        stall,
  input  logic        clear,
  input  logic [1:0]  mode,
  input  logic [2:0]  k_shift,
  frame_avg_if.slave  io
);

  localparam int unsigned DATA_WIDTH = PIXEL_WIDTH * LANES;
  localparam int unsigned WORDS      = IMAGE_DIM * IMAGE_DIM / LANES;
  localparam int unsigned PW         = PIXEL_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  mode_e                 mode_q, mode_d;
  logic [2:0]            k_q, k_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s1_set_q, s1_set_d;
  logic                  ovalid_q, ovalid_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] wb_data;

  assign accept    = io.ivalid && !stall && !clear;
  assign last_word = (ptr_q == ADDR_WIDTH'(WORDS - 1));

  // Stage 1 reads the history word at ptr_q; stage 2 writes the same
  // address back one cycle later, so read and write never coincide.
  frame_avg_lsu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORDS      (WORDS)
  ) lsu (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (ptr_q),
    .rd_data (stored),
    .wr_en   (s1_valid_q && !stall && !clear),
    .wr_addr (s1_addr_q),
    .wr_data (wb_data)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PW-1:0]        x, p, mean, ema, res, wb;
    logic signed [PW:0]   delta, step;

    assign x = s1_data_q[l*PW +: PW];
    assign p = stored[l*PW +: PW];

    always_comb begin
      mean  = PW'(({1'b0, x} + {1'b0, p} + (PW+1)'(1)) >> 1);
      delta = $signed({1'b0, x}) - $signed({1'b0, p});
      step  = delta >>> k_q;
      ema   = PW'($signed({1'b0, p}) + step);
      res   = x;
      wb    = x;
      if (s1_set_q) begin
        case (mode_q)
          MODE_MEAN: res = mean;
          MODE_EMA: begin
            res = ema;
            wb  = ema;
          end
          default: ;
        endcase
      end
    end

    assign result[l*PW +: PW]  = res;
    assign wb_data[l*PW +: PW] = wb;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mode_d     = mode_q;
    k_d        = k_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    s1_last_d  = s1_last_q;
    s1_set_d   = s1_set_q;
    ovalid_d   = ovalid_q;
    odata_d    = odata_q;
    done_d     = done_q;

    if (!stall) begin
      if (clear) begin
        state_d    = ST_UNSET;
        ptr_d      = '0;
        s1_valid_d = 1'b0;
        ovalid_d   = 1'b0;
        done_d     = 1'b0;
      end else begin
        s1_valid_d = io.ivalid;
        if (io.ivalid) begin
          s1_data_d = io.idata;
          s1_addr_d = ptr_q;
          s1_last_d = last_word;
          s1_set_d  = (state_q == ST_SET);
          ptr_d     = last_word ? '0 : ptr_q + ADDR_WIDTH'(1);
          if (last_word) begin
            state_d = ST_SET;
          end
          if (ptr_q == '0) begin
            mode_d = mode_e'(mode);
            k_d    = k_shift;
          end
        end
        ovalid_d = s1_valid_q;
        done_d   = s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
          odata_d = result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_UNSET;
      ptr_q      <= '0;
      mode_q     <= MODE_PASS;
      k_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_set_q   <= 1'b0;
      ovalid_q   <= 1'b0;
      odata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      s1_last_q  <= s1_last_d;
      s1_set_q   <= s1_set_d;
      ovalid_q   <= ovalid_d;
      odata_q    <= odata_d;
      done_q     <= done_d;
    end
  end

  assign io.ovalid     = ovalid_q;
  assign io.odata      = odata_q;
  assign io.frame_done = done_q;

endmodule

// File: tb/tb_frame_avg.sv
// Directed bench for frame_avg on a 4x4 frame of 4-lane words, with
// hand-computed expected words queued ahead of each frame.
module tb_frame_avg;

  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       stall;
  logic       clear;
  logic [1:0] mode;
  logic [2:0] k_shift;

  frame_avg_if #(.DATA_WIDTH(DW)) bus ();

  frame_avg #(
    .IMAGE_DIM   (4),
    .PIXEL_WIDTH (8),
    .LANES       (4),
    .ADDR_WIDTH  (2)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .stall   (stall),
    .clear   (clear),
    .mode    (mode),
    .k_shift (k_shift),
    .io      (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int unsigned lat_q[$];
  int unsigned n_tests  = 0;
  int unsigned n_fail   = 0;
  int unsigned spurious = 0;
  int unsigned acnt     = 0;
  logic        last_active = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {4{b}};
  endfunction

  // Acceptance timestamps in unstalled cycles, for the latency check.
  always @(posedge clk) begin
    if (aresetn && !stall) begin
      if (clear) lat_q.delete();
      else if (bus.ivalid) lat_q.push_back(acnt);
      acnt++;
    end
    last_active = aresetn && !stall;
  end

  always @(negedge clk) begin
    if (last_active && bus.ovalid) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("odata", bus.odata, e.data);
        check_eq("frame_done", bus.frame_done, e.done);
      end
      if (lat_q.size() != 0) check_eq("latency", acnt - lat_q.pop_front(), 2);
    end
  end

  task automatic expect_w(input logic [DW-1:0] d, input logic done);
    exp_t e;
    e.data = d;
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    bus.ivalid = 1'b1;
    bus.idata  = d;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.ivalid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic frame(input logic [DW-1:0] in_w, input logic [DW-1:0] out_w);
    for (int i = 0; i < WORDS; i++) begin
      expect_w(out_w, i == WORDS - 1);
      send(in_w);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.ivalid = 1'b0;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
  endtask

  logic [7:0] st_in  [4] = '{8'h33, 8'h55, 8'h77, 8'h11};
  logic [7:0] st_out [4] = '{8'h44, 8'h55, 8'h66, 8'h33};

  initial begin
    aresetn    = 1'b1;
    stall      = 1'b0;
    clear      = 1'b0;
    mode       = 2'd0;
    k_shift    = 3'd0;
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    #1 aresetn = 1'b0;
    #1;
    check_eq("rst_ovalid", bus.ovalid, 0);
    check_eq("rst_odata", bus.odata, 0);
    check_eq("rst_frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;

    // Echo frame, then pairwise mean; the mid-frame mode change must not apply.
    mode = 2'd0;
    frame(rep(8'h10), rep(8'h10));
    mode = 2'd1;
    for (int i = 0; i < WORDS; i++) begin
      expect_w(rep(8'h19), i == WORDS - 1);
      send(rep(8'h21));
      if (i == 1) mode = 2'd0;
    end
    idle(4);
    do_clear();

    // Exponential average, K=2 twice, then K=0 must return x.
    mode = 2'd0;
    frame(rep(8'h00), rep(8'h00));
    mode = 2'd2; k_shift = 3'd2;
    frame(rep(8'hFF), rep(8'h3F));
    frame(rep(8'hFF), rep(8'h6F));
    k_shift = 3'd0;
    frame(rep(8'h12), rep(8'h12));
    idle(3);
    do_clear();

    // Negative delta, mixed-lane mean, reserved mode.
    mode = 2'd0;
    frame(rep(8'hFF), rep(8'hFF));
    mode = 2'd2; k_shift = 3'd1;
    frame(rep(8'h00), rep(8'h7F));
    mode = 2'd1;
    frame(32'h00FF807F, 32'h40BF807F);
    mode = 2'd3;
    frame(rep(8'h55), rep(8'h55));

    // Five stalled cycles in the middle of a mean frame against stored 0x55.
    mode = 2'd1;
    for (int i = 0; i < WORDS; i++) expect_w(rep(st_out[i]), i == WORDS - 1);
    send(rep(st_in[0]));
    send(rep(st_in[1]));
    @(negedge clk);
    bus.ivalid = 1'b1;
    bus.idata  = rep(st_in[2]);
    stall      = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_ovalid", bus.ovalid, 1);
      check_eq("stall_odata", bus.odata, rep(8'h44));
    end
    stall = 1'b0;
    send(rep(st_in[3]));
    idle(3);

    // Clear on word 2 of a stored-frame pass: word 1 is flushed.
    mode = 2'd1;
    expect_w(rep(8'h22), 1'b0);
    send(rep(8'h11));
    send(rep(8'h11));
    @(negedge clk);
    bus.ivalid = 1'b1;
    bus.idata  = rep(8'h11);
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    bus.ivalid = 1'b0;
    frame(rep(8'h01), rep(8'h01));
    frame(rep(8'h03), rep(8'h02));

    // Asynchronous reset between edges while outputs are streaming.
    expect_w(rep(8'h04), 1'b0);
    send(rep(8'h05));
    send(rep(8'h05));
    send(rep(8'h05));
    @(posedge clk);
    #1;
    check_eq("pre_rst_ovalid", bus.ovalid, 1);
    #1 aresetn = 1'b0;
    #1;
    check_eq("async_rst_ovalid", bus.ovalid, 0);
    check_eq("async_rst_odata", bus.odata, 0);
    check_eq("async_rst_frame_done", bus.frame_done, 0);
    lat_q.delete();
    @(negedge clk);
    bus.ivalid = 1'b0;
    aresetn    = 1'b1;
    frame(rep(8'h07), rep(8'h07));
    frame(rep(8'h09), rep(8'h08));
    idle(6);

    check_eq("drained", exp_q.size(), 0);
    check_eq("spurious", spurious, 0);
    check_eq("lat_drained", lat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
